// File: rtl/instruction_fetch.sv
// Fetch front end for the 128x8 synchronous program ROM: owns the PC, gathers
// opcode (+ optional operand) and hands complete instructions to execute.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_FETCH | pc drives ROM with an opcode address; fault check, pc advances
// S_OP    | opcode byte arrives; decode length, maybe issue operand address
// S_ARG   | operand byte arrives
// S_VALID | instruction presented, held until execute accepts it
// S_FAULT | fetch beyond ROM attempted; frozen until reset
module instruction_fetch #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter int         ROM_DEPTH = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic       has_operand,
    output logic [7:0] instr_pc,
    input  logic       jump_en,
    input  logic [7:0] jump_addr,
    output logic       fetch_fault
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_OP,
        S_ARG,
        S_VALID,
        S_FAULT
    } state_t;

    localparam logic [8:0] ROM_LIMIT = 9'(ROM_DEPTH);

    state_t     state_q;
    logic [7:0] pc_q;
    logic [7:0] opcode_q;
    logic [7:0] operand_q;
    logic       has_operand_q;
    logic [7:0] instr_pc_q;
    logic       valid_q;
    logic       fault_q;

    logic [7:0] pc_inc_d;
    logic       pc_oob_d;
    logic       two_byte_d;

    function automatic logic is_two_byte(input logic [7:0] op);
        return (op >= 8'h86 && op <= 8'h89) ||
               (op >= 8'h96 && op <= 8'h97) ||
               (op >= 8'h20 && op <= 8'h28);
    endfunction

    always_comb begin
        pc_inc_d   = pc_q + 8'd1;
        pc_oob_d   = ({1'b0, pc_q} >= ROM_LIMIT);
        two_byte_d = is_two_byte(rom_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            opcode_q      <= 8'h00;
            operand_q     <= 8'h00;
            has_operand_q <= 1'b0;
            instr_pc_q    <= 8'h00;
            valid_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (pc_oob_d) begin
                        state_q <= S_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        instr_pc_q <= pc_q;
                        pc_q       <= pc_inc_d;
                        state_q    <= S_OP;
                    end
                end
                S_OP: begin
                    opcode_q      <= rom_data;
                    has_operand_q <= two_byte_d;
                    operand_q     <= 8'h00;
                    if (two_byte_d) begin
                        // pc already addresses the operand byte this cycle
                        if (pc_oob_d) begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q    <= pc_inc_d;
                            state_q <= S_ARG;
                        end
                    end else begin
                        state_q <= S_VALID;
                        valid_q <= 1'b1;
                    end
                end
                S_ARG: begin
                    operand_q <= rom_data;
                    state_q   <= S_VALID;
                    valid_q   <= 1'b1;
                end
                S_VALID: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                        if (jump_en) begin
                            pc_q <= jump_addr;
                        end
                    end
                end
                S_FAULT: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_FAULT;
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    assign rom_addr    = pc_q;
    assign instr_valid = valid_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign has_operand = has_operand_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_fault = fault_q;

endmodule
